// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus sequencer.
package otg_hpi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    // Wide enough for any sane phase length at 50 MHz.
    localparam int CNT_W = 8;

endpackage

// File: rtl/otg_hpi_master.sv
// Avalon-MM slave that turns single 16-bit transfers into timed HPI
// pin sequences (setup / strobe / hold / recovery).
module otg_hpi_master
    import otg_hpi_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 3,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n
);

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             is_wr, is_wr_nx;
    logic             request, start, capture;
    logic             cs_n_nx, rd_n_nx, wr_n_nx, oe_nx;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    assign request     = chipselect & (read | write);
    assign start       = (state == IDLE) & request;
    assign waitrequest = request & (state != DONE);
    assign capture     = (state == STROBE) & (cnt == '0) & ~is_wr;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (request) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nx = STROBE;
                    cnt_nx   = STROBE_LD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nx = RECOVER;
                cnt_nx   = RECOVER_LD;
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Pins are registered from the next state so they change in step with it.
    always_comb begin
        is_wr_nx = start ? write : is_wr;
        cs_n_nx  = !(state_nx inside {SETUP, STROBE, HOLD});
        rd_n_nx  = !((state_nx == STROBE) && !is_wr_nx);
        wr_n_nx  = !((state_nx == STROBE) && is_wr_nx);
        oe_nx    = is_wr_nx && (state_nx inside {SETUP, STROBE, HOLD});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            is_wr        <= 1'b0;
            otg_addr     <= '0;
            otg_data_out <= '0;
            otg_data_oe  <= 1'b0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            readdata     <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            is_wr       <= is_wr_nx;
            otg_data_oe <= oe_nx;
            otg_cs_n    <= cs_n_nx;
            otg_rd_n    <= rd_n_nx;
            otg_wr_n    <= wr_n_nx;
            if (start) begin
                otg_addr     <= address;
                otg_data_out <= writedata[15:0];
            end
            if (capture) begin
                readdata <= {16'h0000, otg_data_in};
            end
        end
    end

endmodule

// File: tb/tb_otg_hpi_master.sv
// Scoreboard bench for otg_hpi_master: drives Avalon transfers, models the
// HPI data pad, and checks pin timing and completion against queued results.
module tb_otg_hpi_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [1:0]  otg_addr;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_cs_n, otg_rd_n, otg_wr_n;

    logic [15:0] hpi_word;
    logic [31:0] last_rd;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        is_rd;
        logic [31:0] rdata;
        int          setup_idx;
        int          done_idx;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // HPI device only drives the bus while rd_n is low.
    assign otg_data_in = !otg_rd_n ? hpi_word : 16'h0000;

    otg_hpi_master dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .otg_addr     (otg_addr),
        .otg_data_out (otg_data_out),
        .otg_data_oe  (otg_data_oe),
        .otg_data_in  (otg_data_in),
        .otg_cs_n     (otg_cs_n),
        .otg_rd_n     (otg_rd_n),
        .otg_wr_n     (otg_wr_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one transfer starting just after a rising edge (cycle 0) and
    // follow it to completion; setup_idx is the cycle cs_n should first drop.
    task automatic xfer(input logic rd, input logic wr, input logic [1:0] a,
                        input logic [31:0] wd, input logic [15:0] rword,
                        input int setup_idx, input logic keep);
        exp_t e;
        int   wr_lo, rd_lo, first_cs, i;
        hpi_word    = rword;
        e.is_rd     = rd & !wr;
        if (e.is_rd) last_rd = {16'h0000, rword};
        e.rdata     = last_rd;
        e.setup_idx = setup_idx;
        e.done_idx  = setup_idx + 5;
        sb.push_back(e);
        chipselect = 1'b1; read = rd; write = wr; address = a; writedata = wd;
        wr_lo = 0; rd_lo = 0; first_cs = -1;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!otg_wr_n) wr_lo++;
            if (!otg_rd_n) rd_lo++;
            if (!otg_cs_n) begin
                if (first_cs < 0) first_cs = i;
                check("addr_held", {30'd0, otg_addr}, {30'd0, a});
                check("oe_active", {31'd0, otg_data_oe}, {31'd0, !e.is_rd});
                if (!e.is_rd) check("wdata_held", {16'd0, otg_data_out}, {16'd0, wd[15:0]});
            end
            if (!waitrequest) break;
        end
        e = sb.pop_front();
        check("done_cycle", i, e.done_idx);
        check("setup_cycle", first_cs, e.setup_idx);
        check("wr_low_cycles", wr_lo, e.is_rd ? 0 : 3);
        check("rd_low_cycles", rd_lo, e.is_rd ? 3 : 0);
        check("readdata", readdata, e.rdata);
        check("done_cs_n", {31'd0, otg_cs_n}, 32'd1);
        check("done_oe", {31'd0, otg_data_oe}, 32'd0);
        @(posedge clk);
        #1;
        if (!keep) begin
            chipselect = 1'b0; read = 1'b0; write = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = 32'd0; hpi_word = 16'h0000; last_rd = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cs_n", {31'd0, otg_cs_n}, 32'd1);
        check("rst_rd_n", {31'd0, otg_rd_n}, 32'd1);
        check("rst_wr_n", {31'd0, otg_wr_n}, 32'd1);
        check("rst_oe", {31'd0, otg_data_oe}, 32'd0);
        check("rst_addr", {30'd0, otg_addr}, 32'd0);
        check("rst_dout", {16'd0, otg_data_out}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_wait", {31'd0, waitrequest}, 32'd0);
        @(posedge clk); #1;

        xfer(1'b0, 1'b1, 2'd2, 32'h0000_1234, 16'hDEAD, 1, 1'b0);
        repeat (3) @(posedge clk); #1;
        xfer(1'b1, 1'b0, 2'd0, 32'h0, 16'hBEEF, 1, 1'b0);
        repeat (3) @(posedge clk); #1;

        // Back-to-back: two RECOVER cycles plus IDLE before the next SETUP.
        xfer(1'b0, 1'b1, 2'd1, 32'hFFFF_5A5A, 16'h0000, 1, 1'b1);
        xfer(1'b1, 1'b0, 2'd3, 32'h0, 16'hC0DE, 3, 1'b0);
        repeat (3) @(posedge clk); #1;

        // Read and write together resolve to a write.
        xfer(1'b1, 1'b1, 2'd2, 32'h0000_00AA, 16'h1111, 1, 1'b0);
        @(negedge clk);
        check("idle_wait", {31'd0, waitrequest}, 32'd0);
        repeat (2) @(posedge clk); #1;

        // Reset in the middle of a write strobe.
        chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h0000_5555;
        repeat (3) @(negedge clk);
        check("abort_in_strobe", {31'd0, otg_wr_n}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_wr_n", {31'd0, otg_wr_n}, 32'd1);
        check("abort_cs_n", {31'd0, otg_cs_n}, 32'd1);
        check("abort_oe", {31'd0, otg_data_oe}, 32'd0);
        check("abort_rd_n", {31'd0, otg_rd_n}, 32'd1);
        chipselect = 1'b0; write = 1'b0; reset = 1'b0; last_rd = 32'd0;
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 2'd0, 32'h0, 16'hBEEF, 1, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
